// File: rtl/deskew_collector_if.sv
// deskew_collector_if: skewed-lane input and aligned-row output bundle for deskew_collector.
interface deskew_collector_if #(
   parameter int BITS = 8,
   parameter int DIM = 8,
   parameter int ROWBITS = $clog2(DIM)
);
   logic en;
   logic signed [BITS-1:0] Din [DIM];
   logic signed [BITS-1:0] Dout [DIM];
   logic Dvalid;
   logic [ROWBITS-1:0] Drow;
   logic done;
   modport master (output en, Din, input Dout, Dvalid, Drow, done);
   modport slave (input en, Din, output Dout, Dvalid, Drow, done);
endinterface

// File: rtl/deskew_collector.sv
// deskew_collector: realigns a skewed wavefront (lane i lagging by i) into whole rows.
// DESKEW_ZERO_FILL_EN: force Dout to zero whenever Dvalid would be 0.
module deskew_collector #(
   parameter int BITS = 8,
   parameter int DIM = 8,
   parameter int ROWBITS = $clog2(DIM)
) (
   input logic clk,
   input logic rst_n,
   deskew_collector_if.slave d
);
   localparam int KBITS = $clog2(2*DIM-1);
   localparam logic [KBITS-1:0] KFIRST = KBITS'(DIM-1);
   localparam logic [KBITS-1:0] KLAST = KBITS'(2*DIM-2);
   logic [KBITS-1:0] k, k_nxt;
   logic [DIM-1:0][BITS-1:0] tap;
   logic signed [BITS-1:0] dout_nxt [DIM];
   logic valid_nxt, done_nxt;
   logic [ROWBITS-1:0] row_nxt;
   // lane i is delayed DIM-1-i edges so every lane of a row reaches the output register together
   for (genvar i = 0; i < DIM; i++) begin : g_lane
      if (i < DIM-1) begin : g_dl
         logic signed [BITS-1:0] sr [DIM-1-i];
         always_ff @(posedge clk)
            if (!rst_n) sr <= '{default: '0};
            else if (d.en) begin
               sr[0] <= d.Din[i];
               for (int j = 1; j < DIM-1-i; j++) sr[j] <= sr[j-1];
            end
         assign tap[i] = sr[DIM-2-i];
      end else begin : g_pass
         assign tap[i] = d.Din[i];
      end
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         k <= '0;
         d.Dout <= '{default: '0};
         d.Dvalid <= 1'b0;
         d.Drow <= '0;
         d.done <= 1'b0;
      end else if (d.en) begin
         k <= k_nxt;
         d.Dout <= dout_nxt;
         d.Dvalid <= valid_nxt;
         d.Drow <= row_nxt;
         d.done <= done_nxt;
      end
   always_comb k_nxt = (k == KLAST) ? '0 : k + 1'b1;
   always_comb begin
      valid_nxt = k >= KFIRST;
      row_nxt = valid_nxt ? ROWBITS'(k - KFIRST) : '0;
      done_nxt = k == KLAST;
      for (int j = 0; j < DIM; j++) begin
`ifdef DESKEW_ZERO_FILL_EN
         dout_nxt[j] = valid_nxt ? $signed(tap[j]) : '0;
`else
         dout_nxt[j] = $signed(tap[j]);
`endif
      end
   end
endmodule

// File: tb/tb_deskew_collector.sv
// tb_deskew_collector: drives skewed matrices and checks rows against a matrix-level model.
module tb_deskew_collector;
   localparam int BITS = 8, DIM = 8, ROWBITS = 3, PER = 2*DIM-1;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   deskew_collector_if #(.BITS(BITS), .DIM(DIM), .ROWBITS(ROWBITS)) ifc ();
   deskew_collector #(.BITS(BITS), .DIM(DIM), .ROWBITS(ROWBITS)) dut (.clk(clk), .rst_n(rst_n), .d(ifc));
   int n_checks = 0, n_fail = 0;
   logic [BITS-1:0] mat [2][DIM][DIM];
   bit garbage55 = 0;

   // global edge t belongs to matrix t/PER; lane i carries row kk-i inside its window
   task automatic drive(input int t);
      int m, kk;
      m = t / PER;
      kk = t % PER;
      ifc.en = 1;
      for (int i = 0; i < DIM; i++)
         ifc.Din[i] = (kk >= i && kk - i < DIM) ? mat[m][kk-i][i] : (garbage55 ? 8'h55 : BITS'($urandom));
   endtask

   task automatic random_mat(input int m);
      for (int r = 0; r < DIM; r++)
         for (int i = 0; i < DIM; i++) mat[m][r][i] = BITS'($urandom);
   endtask

   task automatic stream_check(input string name, input int n);
      int dones = 0;
      for (int t = 0; t < n; t++) begin
         int m, kk, r;
         bit ev;
         drive(t);
         @(posedge clk); #1;
         m = t / PER; kk = t % PER; r = kk - DIM + 1; ev = kk >= DIM-1;
         n_checks++;
         if (ifc.Dvalid !== ev) begin n_fail++; $display("FAIL %s Dvalid t=%0d got %b want %b", name, t, ifc.Dvalid, ev); end
         n_checks++;
         if (ifc.done !== (kk == PER-1)) begin n_fail++; $display("FAIL %s done t=%0d got %b want %b", name, t, ifc.done, kk == PER-1); end
         if (ifc.done === 1'b1) dones++;
         if (ev) begin
            n_checks++;
            if (ifc.Drow !== ROWBITS'(r)) begin n_fail++; $display("FAIL %s Drow t=%0d got %0d want %0d", name, t, ifc.Drow, r); end
            for (int i = 0; i < DIM; i++) begin
               n_checks++;
               if (ifc.Dout[i] !== mat[m][r][i]) begin n_fail++; $display("FAIL %s Dout[%0d] t=%0d got %h want %h", name, i, t, ifc.Dout[i], mat[m][r][i]); end
            end
         end
`ifdef DESKEW_ZERO_FILL_EN
         else for (int i = 0; i < DIM; i++) begin
            n_checks++;
            if (ifc.Dout[i] !== '0) begin n_fail++; $display("FAIL %s zerofill Dout[%0d] t=%0d got %h want 00", name, i, t, ifc.Dout[i]); end
         end
`endif
      end
      n_checks++;
      if (dones != n / PER) begin n_fail++; $display("FAIL %s done_count got %0d want %0d", name, dones, n / PER); end
   endtask

   task automatic test_reset;
      rst_n = 0; ifc.en = 0;
      for (int i = 0; i < DIM; i++) ifc.Din[i] = BITS'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (ifc.Dvalid !== 1'b0 || ifc.done !== 1'b0 || ifc.Drow !== '0) begin
         n_fail++; $display("FAIL reset ctrl got v=%b d=%b r=%0d want 0 0 0", ifc.Dvalid, ifc.done, ifc.Drow);
      end
      for (int i = 0; i < DIM; i++) begin
         n_checks++;
         if (ifc.Dout[i] !== '0) begin n_fail++; $display("FAIL reset Dout[%0d] got %h want 00", i, ifc.Dout[i]); end
      end
      rst_n = 1;
   endtask

   task automatic test_single;
      for (int r = 0; r < DIM; r++)
         for (int i = 0; i < DIM; i++) mat[0][r][i] = BITS'(16*r + i);
      garbage55 = 1;
      stream_check("single", PER);
      garbage55 = 0;
   endtask

   task automatic test_signed;
      for (int r = 0; r < DIM; r++)
         for (int i = 0; i < DIM; i++) mat[0][r][i] = ((r + i) % 2) ? 8'h7f : 8'h80;
      stream_check("signed", PER);
   endtask

   task automatic test_back_to_back;
      for (int r = 0; r < DIM; r++)
         for (int i = 0; i < DIM; i++) begin
            mat[0][r][i] = BITS'(16*r + i);
            mat[1][r][i] = BITS'(16*r + i + 100);
         end
      stream_check("b2b", 2*PER);
   endtask

   task automatic test_stall;
      int dones = 0;
      random_mat(0);
      for (int t = 0; t < PER; t++) begin
         int r;
         if (t == 11)
            for (int s = 0; s < 5; s++) begin
               ifc.en = 0;
               for (int i = 0; i < DIM; i++) ifc.Din[i] = BITS'($urandom);
               @(posedge clk); #1;
               n_checks++;
               if (ifc.Dvalid !== 1'b1 || ifc.Drow !== 3'd3 || ifc.done !== 1'b0) begin
                  n_fail++; $display("FAIL stall hold s=%0d got v=%b r=%0d d=%b want 1 3 0", s, ifc.Dvalid, ifc.Drow, ifc.done);
               end
               for (int i = 0; i < DIM; i++) begin
                  n_checks++;
                  if (ifc.Dout[i] !== mat[0][3][i]) begin n_fail++; $display("FAIL stall hold Dout[%0d] got %h want %h", i, ifc.Dout[i], mat[0][3][i]); end
               end
            end
         drive(t);
         @(posedge clk); #1;
         r = t - DIM + 1;
         if (ifc.done === 1'b1) dones++;
         n_checks++;
         if (ifc.Dvalid !== (r >= 0)) begin n_fail++; $display("FAIL stall Dvalid t=%0d got %b want %b", t, ifc.Dvalid, r >= 0); end
         if (r >= 0) begin
            n_checks++;
            if (ifc.Drow !== ROWBITS'(r)) begin n_fail++; $display("FAIL stall Drow t=%0d got %0d want %0d", t, ifc.Drow, r); end
            for (int i = 0; i < DIM; i++) begin
               n_checks++;
               if (ifc.Dout[i] !== mat[0][r][i]) begin n_fail++; $display("FAIL stall Dout[%0d] t=%0d got %h want %h", i, t, ifc.Dout[i], mat[0][r][i]); end
            end
         end
      end
      n_checks++;
      if (dones != 1) begin n_fail++; $display("FAIL stall done_count got %0d want 1", dones); end
   endtask

   task automatic test_reset_mid;
      random_mat(0);
      for (int t = 0; t < 10; t++) begin
         drive(t);
         @(posedge clk);
      end
      #1;
      rst_n = 0;
      drive(10);
      @(posedge clk); #1;
      rst_n = 1;
      n_checks++;
      if (ifc.Dvalid !== 1'b0 || ifc.done !== 1'b0 || ifc.Drow !== '0) begin
         n_fail++; $display("FAIL reset_mid ctrl got v=%b d=%b r=%0d want 0 0 0", ifc.Dvalid, ifc.done, ifc.Drow);
      end
      for (int i = 0; i < DIM; i++) begin
         n_checks++;
         if (ifc.Dout[i] !== '0) begin n_fail++; $display("FAIL reset_mid Dout[%0d] got %h want 00", i, ifc.Dout[i]); end
      end
      random_mat(0);
      stream_check("reset_fresh", PER);
   endtask

   initial begin
      test_reset();
      test_single();
      test_signed();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/deskew_collector.md
# deskew_collector

Output-side counterpart to memA. memA takes whole rows and emits them as a skewed wavefront, with lane i lagging lane 0 by i cycles. deskew_collector takes such a skewed wavefront, for example a systolic array result stream or a memA loopback, and realigns it into whole rows. It presents one aligned row per cycle with a row index, a valid flag and an end-of-matrix pulse. It sits between the array's streaming outputs and any row-addressed consumer (result memory, host readback).

## Interface
Parameters:
- BITS, 8: width of each lane element (signed).
- DIM, 8: number of lanes, which is also rows per matrix; must be ≥2.
- ROWBITS, $clog2(DIM): width of the row index.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  advance enable; when low, all state holds (stall).
- Din  in  [BITS-1:0] x DIM, signed  skewed input lanes.
- Dout  out  [BITS-1:0] x DIM, signed  aligned row output, registered.
- Dvalid  out  1  Dout holds a valid row.
- Drow  out  ROWBITS  index of the row currently on Dout.
- done  out  1  single-cycle pulse, coincident with row DIM-1 on Dout.

## Operation
- Cycle index k counts en-high clock edges, starting at 0 for a matrix. The counter runs 0..2*DIM-2 and wraps to 0, so each matrix takes 2*DIM-1 enabled edges. Matrices may be streamed back-to-back with no gap.
- Input contract: element (row r, lane i) is on Din[i] at the enabled edge k = r + i.
  - Lane i is meaningful only for k in [i, i+DIM-1].
  - Din outside that window is don't-care and must not affect valid output.
- Lane i passes through a delay line of DIM-1-i stages, followed by a common output register.
  - Lane DIM-1 has no delay stages, only the output register.
  - Delay lines and the output register shift only when en=1.
- States, implied by the counter:
  - FILL: k in 0..DIM-2. Dvalid=0.
  - DRAIN: k in DIM-1..2*DIM-2. At edge k, Dout is loaded with row r=k-DIM+1, Dvalid=1, Drow=r.
  - done=1 on the edge with k=2*DIM-2, together with Drow=DIM-1.
- Arithmetic: no transformation of data; values pass bit-exact, with sign preserved.
- Stall: en=0 for any number of cycles freezes the counter, the delay lines, Dout, Dvalid, Drow and done. done is re-asserted only if it was already 1, i.e. a pulse spans the stall and drops on the next enabled edge.
- Reset, including in mid-matrix: all delay stages, Dout, Dvalid, Drow, done and the counter are cleared. The next enabled edge is k=0 of a new matrix, and the partial matrix is discarded.
- rst_n=0 takes priority over en.

## Timing
- Reset values: Dout all 0, Dvalid 0, Drow 0, done 0, counter 0.
- Latency: row r becomes visible after the enabled edge r+DIM-1.
  - This is DIM-1 enabled edges after its lane-0 element was sampled.
  - It is 0 edges after its lane-(DIM-1) element was sampled; the data is registered on that same edge.
- Throughput:
  - One row per enabled cycle during DRAIN.
  - DIM rows per 2*DIM-1 enabled cycles for back-to-back matrices.
- After wrap (k=0 of the next matrix), Dvalid falls to 0 on that edge.

## Configuration
- DESKEW_ZERO_FILL_EN defined: Dout is forced to all zeros on every edge where Dvalid would be 0, during FILL and after reset.
- Undefined: during FILL, Dout takes whatever the delay lines hold (stale or don't-care data), and consumers must qualify it with Dvalid.
- Dvalid, Drow and done behave identically in both builds.

## Test plan
- Single matrix, DIM=8, element (r,i)=16*r+i driven per the skew contract, en held high:
  - Dout=row r = {16r+0..16r+7} with Drow=r after edges 7..14.
  - Dvalid=1 exactly on those 8 edges.
  - done=1 only after edge 14.
- Signed pass-through: all elements -128 or 127 in a checkerboard → exact values out, no sign loss.
- Back-to-back: two matrices, the second with values +100, streamed without a gap:
  - Second matrix rows appear after edges 22..29.
  - Dvalid=0 for edges 15..21.
  - Two done pulses.
- Stall: en=0 for 5 cycles after edge 10:
  - Dout (row 3) and Drow=3 hold.
  - Row 4 appears on the first enabled edge after the stall.
  - No extra rows or done pulses.
- Reset mid-matrix: rst_n=0 after edge 9, for one cycle:
  - All outputs 0 the next cycle.
  - A fresh matrix then produces correct rows 0..7 with no residue from the aborted one.
- Garbage outside the window: drive 0x55 on Din[i] outside [i, i+7] → Dout rows unaffected. With DESKEW_ZERO_FILL_EN, Dout=0 during FILL.
